octave_fold_filter: RTL and testbench
=====================================

Name: octave_fold_filter

Overview:
Downstream consumer of the DFT bin array. On each bin-update strobe it folds the BPO*OC DFT magnitudes into BPO octave-folded bins by summing the same note across all octaves. It scales and saturates each sum, then applies a per-bin first-order IIR smoother. The smoothed folded bins feed the later note-finding stage.

Parameters:
BPO, 24, bins per octave (folded output count)
OC, 5, octave count; input array length is BPO*OC
INW, 36, width of each unsigned input bin
OUTW, 32, width of each unsigned folded/filtered output bin
INSHIFT, 3, right shift applied to the octave sum before saturation
IIRSHIFT, 2, IIR coefficient exponent; alpha = 2^-IIRSHIFT

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (asserted when 0)
inBins  in  [0:BPO*OC-1] x INW  unsigned DFT magnitudes; bin i = octave i/BPO, note i%BPO
binsValid  in  1  one-cycle strobe: inBins holds a new frame
foldedBins  out  [0:BPO-1] x OUTW  unsigned smoothed folded bins (filter state)
outValid  out  1  one-cycle pulse: all foldedBins updated for this frame
busy  out  1  high while a frame is being processed
overrun  out  1  one-cycle pulse: binsValid arrived while busy and was dropped

Behaviour:
- Reset (rst=0, async): foldedBins all 0, outValid=0, busy=0, overrun=0, state IDLE, idx=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: binsValid=1 at an edge -> RUN, idx=0, busy=1 from that edge.
- RUN: each edge updates foldedBins[idx], then idx++. At idx==BPO-1 the update completes and the FSM goes to DONE.
- DONE: outValid=1 for exactly one cycle, busy stays 1. The next edge goes to IDLE with busy=0 and outValid=0.
- Latency: binsValid sampled at edge t. Updates occur at edges t+1..t+BPO. outValid is high in the cycle after edge t+BPO+1 (BPO+1 edges after acceptance).
- Input stability: inBins must be held stable from the binsValid edge through edge t+BPO. The block does not snapshot inBins. The upstream DFT update period (250+ cycles) guarantees this.
- Per-bin datapath, all combinational within one cycle:
  - sum = sum over k=0..OC-1 of inBins[idx + k*BPO], width INW+ceil(log2 OC).
  - x = sum >> INSHIFT, saturated to 2^OUTW-1.
  - diff = x - y (signed, OUTW+1 bits).
  - y_new = y + (diff >>> IIRSHIFT), using arithmetic shift (floor).
  - y_new always lies within [0, 2^OUTW-1], so no clamp is needed on y.
- IIRSHIFT=0 gives y_new = x exactly.
- binsValid in RUN or DONE: ignored; overrun pulses for one cycle on the following edge. binsValid in the same cycle that DONE returns to IDLE is also ignored (no pending queue).
- foldedBins entries change only during RUN. Entries not yet updated hold the previous frame's values.
- Reset mid-RUN: all state cleared immediately, no outValid; the frame is lost.

Decomposition:
- Shared package dft_pkg: BPO, OC, INW, OUTW constants; typedefs bin_t (INW unsigned) and fbin_t (OUTW unsigned). The package is shared with the DFT and the downstream note stage.
- One sub-module, octave_fold_sum: combinational OC-input adder with shift and saturation, producing x for a given idx.
- The IIR update and FSM stay in the top module.

Test Plan:
- Reset: hold rst=0 with random inBins -> foldedBins all 0, busy/outValid/overrun 0; release and idle 10 cycles -> still 0.
- Uniform frames, all inBins=8:
  - Frame 1: outValid exactly 25 edges after the binsValid edge; all foldedBins=1 (sum 40, x=5, diff 5>>>2=1).
  - Frame 2: all foldedBins=2.
  - Frame 3: all foldedBins stay 2 (diff 3>>>2=0).
- Fold mapping: only inBins[30]=800, others 0 -> foldedBins[6]=25 (x=100), all others 0; repeat with inBins[102]=800 -> same index 6 affected.
- Saturation and decay:
  - All inBins=2^36-1 -> x=0xFFFFFFFF; every foldedBin becomes 0x3FFFFFFF.
  - Then all 0 -> every foldedBin becomes 0x2FFFFFFF (diff >>> 2 = -0x10000000).
  - A bin at 1 with x=0 decays to 0 and never goes negative.
- Overrun: second binsValid 10 cycles after the first -> overrun pulses once, exactly one outValid, results equal to single-frame values.
- Reset mid-RUN: assert rst at idx=12 -> all foldedBins 0 immediately, no outValid; the next frame then behaves as frame 1 from reset.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared constants and bin types for the DFT, the octave fold filter and
// the downstream note stage.
package dft_pkg;

  localparam int BPO  = 24;              // bins per octave
  localparam int OC   = 5;               // octave count
  localparam int INW  = 36;              // DFT magnitude width
  localparam int OUTW = 32;              // folded / smoothed bin width

  localparam int SUMW = INW + $clog2(OC); // width of an octave sum
  localparam int IDXW = $clog2(BPO);      // folded-bin index width

  typedef logic [INW-1:0]  bin_t;
  typedef logic [OUTW-1:0] fbin_t;

endpackage

// File: rtl/octave_fold_sum.sv
// Combinational octave fold: sums one note across all octaves, then
// scales the sum down and saturates it to the folded-bin width.
module octave_fold_sum
  import dft_pkg::*;
#(
  parameter int INSHIFT = 3
) (
  input  bin_t            inBins [0:BPO*OC-1],
  input  logic [IDXW-1:0] idx,
  output fbin_t           x
);

  localparam int AW = $clog2(BPO*OC);

  logic [SUMW-1:0] sum;
  logic [AW-1:0]   j;

  // Scale the octave sum and clamp it to the largest folded value.
  function automatic fbin_t sat_shift(input logic [SUMW-1:0] s);
    logic [SUMW-1:0] sh;
    sh = s >> INSHIFT;
    if (|sh[SUMW-1:OUTW]) return '1;
    return sh[OUTW-1:0];
  endfunction

  // Same note in every octave: bins idx, idx+BPO, idx+2*BPO, ...
  always_comb begin
    sum = '0;
    j   = '0;
    for (int k = 0; k < OC; k++) begin
      j   = AW'(idx) + AW'(k * BPO);
      sum = sum + SUMW'(inBins[j]);
    end
  end

  assign x = sat_shift(sum);

endmodule

// File: rtl/octave_fold_filter.sv
// Octave fold filter: on each bin-update strobe, walks the BPO folded bins
// one per cycle, folding the DFT magnitudes across octaves and running a
// first-order IIR smoother y += (x - y) >>> IIRSHIFT on each bin.
module octave_fold_filter
  import dft_pkg::*;
#(
  parameter int INSHIFT  = 3,
  parameter int IIRSHIFT = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  bin_t  inBins [0:BPO*OC-1],
  input  logic  binsValid,
  output fbin_t foldedBins [0:BPO-1],
  output logic  outValid,
  output logic  busy,
  output logic  overrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state;
  logic [IDXW-1:0] idx;
  fbin_t           x_p0;
  fbin_t           y_new_p0;

  // One IIR step; the floor shift keeps the result inside [min(x,y), max(x,y)],
  // so it never leaves the unsigned OUTW range and needs no clamp.
  function automatic fbin_t iir_step(input fbin_t y, input fbin_t x);
    logic signed [OUTW+1:0] diff;
    logic signed [OUTW+1:0] acc;
    diff = $signed({2'b00, x}) - $signed({2'b00, y});
    acc  = $signed({2'b00, y}) + (diff >>> IIRSHIFT);
    return acc[OUTW-1:0];
  endfunction

  // ---- stage p0: fold, scale, saturate and smooth the bin at idx ----
  octave_fold_sum #(
    .INSHIFT(INSHIFT)
  ) u_fold (
    .inBins(inBins),
    .idx   (idx),
    .x     (x_p0)
  );

  assign y_new_p0 = iir_step(foldedBins[idx], x_p0);
  assign busy     = (state != ST_IDLE);

  // Sequencer: accept a frame, step idx through all bins, then flag completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      outValid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= binsValid && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          outValid <= 1'b0;
          if (binsValid) begin
            state <= ST_RUN;
            idx   <= '0;
          end
        end
        ST_RUN: begin
          if (idx == IDXW'(BPO - 1)) begin
            state <= ST_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (!outValid) begin
            outValid <= 1'b1;
          end else begin
            outValid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          outValid <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p0 -> filter state: write back the smoothed bin ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < BPO; b++) foldedBins[b] <= '0;
    end else if (state == ST_RUN) begin
      foldedBins[idx] <= y_new_p0;
    end
  end

endmodule

// File: tb/tb_octave_fold_filter.sv
// Self-checking bench for octave_fold_filter with a behavioural model of
// the fold, saturation and IIR smoothing.
module tb_octave_fold_filter;
  import dft_pkg::*;

  localparam int INSHIFT  = 3;
  localparam int IIRSHIFT = 2;
  localparam longint FMAX = (64'd1 << OUTW) - 1;
  localparam longint IMAX = (64'd1 << INW) - 1;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  bin_t  in_bins [0:BPO*OC-1];
  logic  binsValid = 1'b0;
  fbin_t foldedBins [0:BPO-1];
  logic  outValid, busy, overrun;

  int checks = 0;
  int errors = 0;
  longint model_y [BPO];

  octave_fold_filter #(.INSHIFT(INSHIFT), .IIRSHIFT(IIRSHIFT)) dut (
    .clk(clk), .rst(rst), .inBins(in_bins), .binsValid(binsValid),
    .foldedBins(foldedBins), .outValid(outValid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference: note n collects inBins[n + k*BPO]; y moves a quarter of the way to x, rounded down.
  task automatic model_frame();
    for (int n = 0; n < BPO; n++) begin
      longint s, x, d, step, div;
      s = 0;
      for (int k = 0; k < OC; k++) s += longint'(in_bins[n + k*BPO]);
      x = s / (64'd1 << INSHIFT);
      if (x > FMAX) x = FMAX;
      d = x - model_y[n];
      div = 64'd1 << IIRSHIFT;
      if (d >= 0) step = d / div;
      else        step = -((-d + div - 1) / div);
      model_y[n] = model_y[n] + step;
    end
  endtask

  task automatic fill(input longint v);
    for (int i = 0; i < BPO*OC; i++) in_bins[i] = bin_t'(v);
  endtask

  task automatic compare_bins(input string name);
    for (int n = 0; n < BPO; n++) begin
      checks++;
      if (foldedBins[n] !== fbin_t'(model_y[n])) begin
        errors++;
        $display("FAIL %s bin%0d: got %h expected %h", name, n, foldedBins[n], fbin_t'(model_y[n]));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    binsValid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int n = 0; n < BPO; n++) model_y[n] = 0;
  endtask

  // Accept a frame, measure latency to outValid, check the pulse shape and results.
  task automatic run_frame(input string name);
    int n;
    @(negedge clk);
    binsValid = 1'b1;
    @(negedge clk);
    binsValid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_accept: got %b expected 1", name, busy);
    end
    n = 0;
    while (!outValid && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== BPO + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected %0d", name, n, BPO + 1);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_with_outValid: got %b expected 1", name, busy);
    end
    model_frame();
    compare_bins(name);
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end_of_frame outValid/busy: got %b/%b expected 0/0", name, outValid, busy);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < BPO*OC; i++) in_bins[i] = bin_t'({$urandom, $urandom});
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int n = 0; n < BPO; n++) model_y[n] = 0;
    compare_bins("reset_hold");
    checks++;
    if ({busy, outValid, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {busy, outValid, overrun});
    end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    compare_bins("reset_idle");
    checks++;
    if ({busy, outValid, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL idle_flags: got %b expected 000", {busy, outValid, overrun});
    end
  endtask

  task automatic test_uniform();
    int exp_v [3] = '{1, 2, 2};
    do_reset();
    fill(8);
    for (int f = 0; f < 3; f++) begin
      run_frame($sformatf("uniform_f%0d", f + 1));
      checks++;
      if (foldedBins[BPO-1] !== fbin_t'(exp_v[f])) begin
        errors++;
        $display("FAIL uniform_const_f%0d: got %0d expected %0d", f + 1, foldedBins[BPO-1], exp_v[f]);
      end
    end
  endtask

  task automatic test_fold_map();
    do_reset();
    fill(0);
    in_bins[30] = 800;
    run_frame("fold_30");
    checks++;
    if (foldedBins[6] !== 32'd25 || foldedBins[5] !== 32'd0 || foldedBins[7] !== 32'd0) begin
      errors++;
      $display("FAIL fold_30_const: got %0d/%0d/%0d expected 0/25/0", foldedBins[5], foldedBins[6], foldedBins[7]);
    end
    do_reset();
    fill(0);
    in_bins[102] = 800;
    run_frame("fold_102");
  endtask

  task automatic test_saturation();
    do_reset();
    fill(IMAX);
    run_frame("sat_max");
    checks++;
    if (foldedBins[0] !== 32'h3FFF_FFFF) begin
      errors++;
      $display("FAIL sat_max_const: got %h expected 3fffffff", foldedBins[0]);
    end
    fill(0);
    run_frame("sat_decay");
    checks++;
    if (foldedBins[BPO-1] !== 32'h2FFF_FFFF) begin
      errors++;
      $display("FAIL sat_decay_const: got %h expected 2fffffff", foldedBins[BPO-1]);
    end
    do_reset();
    fill(0);
    in_bins[3] = 32;          // x = 4 -> y goes 0 -> 1
    run_frame("small_up");
    fill(0);
    run_frame("small_down");
    run_frame("small_floor");
    checks++;
    if (foldedBins[3] !== 32'd0) begin
      errors++;
      $display("FAIL small_floor_const: got %h expected 0", foldedBins[3]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 6; f++) begin
      int sh;
      sh = $urandom_range(0, 30);
      for (int i = 0; i < BPO*OC; i++)
        in_bins[i] = bin_t'({$urandom, $urandom} >> sh);
      run_frame($sformatf("random_f%0d", f));
    end
  endtask

  task automatic test_overrun();
    int ovc, ovl;
    do_reset();
    fill(8);
    @(negedge clk);
    binsValid = 1'b1;
    @(negedge clk);
    binsValid = 1'b0;
    ovc = 0;
    ovl = 0;
    for (int n = 0; n < 45; n++) begin
      if (n > 0) @(negedge clk);
      if (overrun)  ovc++;
      if (outValid) ovl++;
      binsValid = (n == 10);
    end
    checks++;
    if (ovc !== 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d expected 1", ovc);
    end
    checks++;
    if (ovl !== 1) begin
      errors++;
      $display("FAIL overrun_outValid_count: got %0d expected 1", ovl);
    end
    model_frame();
    compare_bins("overrun_result");
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    fill(8);
    @(negedge clk);
    binsValid = 1'b1;
    @(negedge clk);
    binsValid = 1'b0;
    n = 0;
    while (!outValid && n < 60) begin
      @(negedge clk);
      n++;
    end
    binsValid = 1'b1;           // arrives as the block returns to idle
    @(negedge clk);
    binsValid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_strobe overrun/busy: got %b/%b expected 1/0", overrun, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL late_strobe_dropped busy/overrun: got %b/%b expected 0/0", busy, overrun);
    end
    model_frame();
    compare_bins("late_strobe_result");
  endtask

  task automatic test_reset_mid();
    int ovl;
    do_reset();
    fill(8);
    @(negedge clk);
    binsValid = 1'b1;
    @(negedge clk);
    binsValid = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (foldedBins[11] !== 32'd1 || foldedBins[12] !== 32'd0) begin
      errors++;
      $display("FAIL mid_progress bin11/bin12: got %0d/%0d expected 1/0", foldedBins[11], foldedBins[12]);
    end
    rst = 1'b0;
    #1;
    for (int n = 0; n < BPO; n++) model_y[n] = 0;
    compare_bins("mid_reset");
    checks++;
    if ({busy, outValid} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_flags: got %b expected 00", {busy, outValid});
    end
    @(negedge clk);
    rst = 1'b1;
    ovl = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (outValid) ovl++;
    end
    checks++;
    if (ovl !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_outValid: got %0d pulses expected 0", ovl);
    end
    run_frame("after_mid_reset");
    checks++;
    if (foldedBins[0] !== 32'd1) begin
      errors++;
      $display("FAIL after_mid_reset_const: got %0d expected 1", foldedBins[0]);
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_fold_map();
    test_saturation();
    test_random();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
